// File: rtl/bcd_pkg.sv
// Shared BCD constants and nibble sanitising for the display counter path.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  // Force any non-BCD nibble (A..F) down to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with increment/decrement, ripple carry/borrow and clamped load.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_nib,
  input  logic             i_cnt,
  input  logic             i_up,
  output logic [BCD_W-1:0] o_digit,
  output logic             o_carry_c
);

  logic [BCD_W-1:0] r_digit;
  logic [BCD_W-1:0] w_next;

  // Next value and carry/borrow into the following digit.
  always_comb begin
    w_next    = r_digit;
    o_carry_c = 1'b0;
    if (i_up) begin
      if (r_digit >= BCD_MAX) begin
        w_next    = BCD_MIN;
        o_carry_c = i_cnt;
      end else begin
        w_next = r_digit + BCD_W'(1);
      end
    end else begin
      if (r_digit == BCD_MIN) begin
        w_next    = BCD_MAX;
        o_carry_c = i_cnt;
      end else begin
        w_next = r_digit - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= BCD_MIN;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_nib);
    end else if (i_cnt) begin
      r_digit <= w_next;
    end
  end

  assign o_digit = r_digit;

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with step prescaler, wrap/saturate limits and parallel load.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up_down,
  input  logic                        mode_sat,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
  output logic [BCD_W*NUM_DIGITS-1:0] digits,
  output logic                        step,
  output logic                        wrap,
  output logic                        at_limit
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]       r_presc;
  logic                r_step;
  logic                r_wrap;
  logic                w_step_edge;
  logic                w_all9;
  logic                w_all0;
  logic                w_lim;
  logic                w_adv;
  logic [NUM_DIGITS:0] w_cnt;

  // Step edge qualification and limit detection; load suppresses any step.
  always_comb begin
    w_step_edge = en && !load && (r_presc == PRE_LAST);
    w_all9      = 1'b1;
    w_all0      = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digits[i*BCD_W +: BCD_W] != BCD_MAX) w_all9 = 1'b0;
      if (digits[i*BCD_W +: BCD_W] != BCD_MIN) w_all0 = 1'b0;
    end
    w_lim = up_down ? w_all9 : w_all0;
    w_adv = w_step_edge && !(mode_sat && w_lim);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (load || w_step_edge) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Carry out of the top digit only occurs on a wrap-mode rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_step <= w_step_edge;
      r_wrap <= w_cnt[NUM_DIGITS];
    end
  end

  assign w_cnt[0] = w_adv;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .rst_n      (rst),
      .i_load     (load),
      .i_load_nib (load_value[g*BCD_W +: BCD_W]),
      .i_cnt      (w_cnt[g]),
      .i_up       (up_down),
      .o_digit    (digits[g*BCD_W +: BCD_W]),
      .o_carry_c  (w_cnt[g+1])
    );
  end

  assign step     = r_step;
  assign wrap     = r_wrap;
  assign at_limit = w_lim;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n: two-digit DIV=4 instance plus a DIV=1 instance.
module tb_bcd_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up_down, mode_sat, load;
  logic [7:0] load_value;
  logic [7:0] digits;
  logic       step, wrap, at_limit;
  logic       en1;
  logic [7:0] digits1;
  logic       step1, wrap1, at_limit1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.NUM_DIGITS(2), .DIV(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .mode_sat(mode_sat),
    .load(load), .load_value(load_value), .digits(digits), .step(step),
    .wrap(wrap), .at_limit(at_limit)
  );

  bcd_updown_counter_n #(.NUM_DIGITS(2), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .up_down(1'b1), .mode_sat(1'b0),
    .load(1'b0), .load_value(8'h00), .digits(digits1), .step(step1),
    .wrap(wrap1), .at_limit(at_limit1)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return {4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; up_down = 1'b1; mode_sat = 1'b0;
    load = 1'b0; load_value = 8'h00; en1 = 1'b0;
    #2;
    checks++; if (digits !== 8'h00) begin failures++; $display("FAIL reset_digits got=%h exp=00", digits); end
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", step); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (at_limit !== 1'b0) begin failures++; $display("FAIL reset_at_limit_up got=%b exp=0", at_limit); end
    up_down = 1'b0;
    #1;
    checks++; if (at_limit !== 1'b1) begin failures++; $display("FAIL reset_at_limit_down got=%b exp=1", at_limit); end
    up_down = 1'b1;
    tick();
    checks++; if (digits !== 8'h00 || step !== 1'b0) begin failures++; $display("FAIL reset_hold got=%h/%b exp=00/0", digits, step); end
    rst = 1'b1;
  endtask

  task automatic test_count_up();
    for (int n = 1; n <= 100; n++) begin
      repeat (3) begin
        tick();
        checks++;
        if (step !== 1'b0 || wrap !== 1'b0) begin
          failures++; $display("FAIL up_idle n=%0d step=%b wrap=%b exp=0/0", n, step, wrap);
        end
      end
      tick();
      checks++;
      if (digits !== to_bcd(n % 100)) begin
        failures++; $display("FAIL up_digits n=%0d got=%h exp=%h", n, digits, to_bcd(n % 100));
      end
      checks++;
      if (step !== 1'b1 || wrap !== (n == 100)) begin
        failures++; $display("FAIL up_pulse n=%0d step=%b wrap=%b exp=1/%b", n, step, wrap, (n == 100));
      end
    end
  endtask

  task automatic test_count_down();
    logic [7:0] exp_d [3];
    logic       exp_w [3];
    exp_d = '{8'h99, 8'h98, 8'h97};
    exp_w = '{1'b1, 1'b0, 1'b0};
    up_down = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      tick();
      checks++;
      if (digits !== exp_d[k] || step !== 1'b1 || wrap !== exp_w[k]) begin
        failures++;
        $display("FAIL down_step k=%0d got=%h/%b/%b exp=%h/1/%b", k, digits, step, wrap, exp_d[k], exp_w[k]);
      end
    end
    load = 1'b1; load_value = 8'h10;
    tick();
    load = 1'b0;
    checks++; if (digits !== 8'h10 || step !== 1'b0) begin failures++; $display("FAIL down_load10 got=%h/%b exp=10/0", digits, step); end
    repeat (4) tick();
    checks++; if (digits !== 8'h09 || step !== 1'b1) begin failures++; $display("FAIL down_borrow got=%h/%b exp=09/1", digits, step); end
  endtask

  task automatic test_saturate();
    mode_sat = 1'b1; up_down = 1'b1;
    load = 1'b1; load_value = 8'h98;
    tick();
    load = 1'b0;
    repeat (4) tick();
    checks++;
    if (digits !== 8'h99 || step !== 1'b1 || wrap !== 1'b0 || at_limit !== 1'b1) begin
      failures++; $display("FAIL sat_reach got=%h/%b/%b/%b exp=99/1/0/1", digits, step, wrap, at_limit);
    end
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      tick();
      checks++;
      if (digits !== 8'h99 || step !== 1'b1 || wrap !== 1'b0 || at_limit !== 1'b1) begin
        failures++; $display("FAIL sat_hold k=%0d got=%h/%b/%b/%b exp=99/1/0/1", k, digits, step, wrap, at_limit);
      end
    end
    up_down = 1'b0;
    #1;
    checks++; if (at_limit !== 1'b0) begin failures++; $display("FAIL sat_at_limit_flip got=%b exp=0", at_limit); end
    repeat (4) tick();
    checks++; if (digits !== 8'h98 || step !== 1'b1) begin failures++; $display("FAIL sat_down got=%h/%b exp=98/1", digits, step); end
    mode_sat = 1'b0; up_down = 1'b1;
  endtask

  task automatic test_load();
    load = 1'b1; load_value = 8'h5C;
    tick();
    load = 1'b0;
    checks++; if (digits !== 8'h59 || step !== 1'b0) begin failures++; $display("FAIL load_clamp_lo got=%h/%b exp=59/0", digits, step); end
    load = 1'b1; load_value = 8'hFA;
    tick();
    load = 1'b0;
    checks++; if (digits !== 8'h99) begin failures++; $display("FAIL load_clamp_both got=%h exp=99", digits); end
    repeat (3) tick();
    load = 1'b1; load_value = 8'h37;
    tick();
    load = 1'b0;
    checks++; if (digits !== 8'h37 || step !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL load_on_step got=%h/%b/%b exp=37/0/0", digits, step, wrap); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (step !== 1'b0 || digits !== 8'h37) begin failures++; $display("FAIL load_gap k=%0d got=%h/%b exp=37/0", k, digits, step); end
    end
    tick();
    checks++; if (digits !== 8'h38 || step !== 1'b1) begin failures++; $display("FAIL load_next_step got=%h/%b exp=38/1", digits, step); end
  endtask

  task automatic test_enable();
    load = 1'b1; load_value = 8'h00;
    tick();
    load = 1'b0;
    repeat (2) tick();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (digits !== 8'h00 || step !== 1'b0) begin failures++; $display("FAIL en_freeze k=%0d got=%h/%b exp=00/0", k, digits, step); end
    end
    en = 1'b1;
    tick();
    checks++; if (digits !== 8'h00 || step !== 1'b0) begin failures++; $display("FAIL en_resume1 got=%h/%b exp=00/0", digits, step); end
    tick();
    checks++; if (digits !== 8'h01 || step !== 1'b1) begin failures++; $display("FAIL en_resume2 got=%h/%b exp=01/1", digits, step); end
  endtask

  task automatic test_div1();
    en1 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (digits1 !== to_bcd(n) || step1 !== 1'b1) begin
        failures++; $display("FAIL div1_count n=%0d got=%h/%b exp=%h/1", n, digits1, step1, to_bcd(n));
      end
    end
    en1 = 1'b0;
    tick();
    checks++; if (digits1 !== 8'h12 || step1 !== 1'b0) begin failures++; $display("FAIL div1_stop got=%h/%b exp=12/0", digits1, step1); end
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_value = 8'h46;
    tick();
    load = 1'b0;
    repeat (4) tick();
    checks++; if (digits !== 8'h47 || step !== 1'b1) begin failures++; $display("FAIL arst_pre got=%h/%b exp=47/1", digits, step); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (digits !== 8'h00) begin failures++; $display("FAIL arst_digits got=%h exp=00", digits); end
    checks++; if (step !== 1'b0 || wrap !== 1'b0) begin failures++; $display("FAIL arst_pulses got=%b/%b exp=0/0", step, wrap); end
    checks++; if (at_limit !== 1'b0) begin failures++; $display("FAIL arst_at_limit got=%b exp=0", at_limit); end
    checks++; if (digits1 !== 8'h00) begin failures++; $display("FAIL arst_digits1 got=%h exp=00", digits1); end
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (digits !== 8'h00 || step !== 1'b0) begin failures++; $display("FAIL arst_resume k=%0d got=%h/%b exp=00/0", k, digits, step); end
    end
    tick();
    checks++; if (digits !== 8'h01 || step !== 1'b1) begin failures++; $display("FAIL arst_first_step got=%h/%b exp=01/1", digits, step); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load();
    test_enable();
    test_div1();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
